// File: rtl/adc_pkg.sv
// Shared ADC-path constants, buffer state encoding and window element slicing.
// Used by the reader, the window buffer, the median sorter and the top level.
package adc_pkg;

    localparam int ADC_DATA_WIDTH = 12;
    localparam int MEDIAN_WINDOW  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_PRIMED  = 2'd2
    } state_e;

    // Bit position of element idx inside a flattened window bus.
    function automatic int elem_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sample_shift_reg.sv
// DATA_COUNT x DATA_WIDTH shift register; new samples enter at the top element
// and the window moves toward element 0. Exposes the post-shift contents.
module sample_shift_reg #(
    parameter int DATA_COUNT = 16,
    parameter int DATA_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             shift_en_i,
    input  logic                             clear_i,
    input  logic [DATA_WIDTH-1:0]            din_i,
    output logic [DATA_COUNT*DATA_WIDTH-1:0] shift_data_o
);

    localparam int TOTAL_W = DATA_COUNT * DATA_WIDTH;

    logic [TOTAL_W-1:0] data_q;
    logic [TOTAL_W-1:0] data_d;
    logic [TOTAL_W-1:0] shifted_s;

    // Next contents: clear dominates shift, otherwise hold.
    always_comb begin
        shifted_s = {din_i, data_q[TOTAL_W-1:DATA_WIDTH]};
        data_d    = data_q;
        if (clear_i) begin
            data_d = {TOTAL_W{1'b0}};
        end else if (shift_en_i) begin
            data_d = shifted_s;
        end else begin
            data_d = data_q;
        end
    end

    // Contents register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {TOTAL_W{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    // The window as it would look after shifting in din_i this cycle.
    assign shift_data_o = shifted_s;

endmodule

// File: rtl/adc_window_buffer.sv
// Collects ADC samples into a DATA_COUNT-deep block or sliding window and hands
// snapshots to the sorter over a valid/ack handshake with overrun counting.
module adc_window_buffer
    import adc_pkg::*;
#(
    parameter int DATA_COUNT = MEDIAN_WINDOW,
    parameter int DATA_WIDTH = ADC_DATA_WIDTH,
    parameter int STRIDE     = 16,
    parameter int OVR_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sample_valid,
    input  logic [DATA_WIDTH-1:0]              sample_data,
    input  logic                               flush,
    input  logic                               window_ack,
    output logic [DATA_COUNT*DATA_WIDTH-1:0]   window_data,
    output logic                               window_valid,
    output logic [$clog2(DATA_COUNT+1)-1:0]    fill_count,
    output logic                               primed,
    output logic [OVR_WIDTH-1:0]               overrun_count
);

    localparam int TOTAL_W = DATA_COUNT * DATA_WIDTH;
    localparam int FILL_W  = $clog2(DATA_COUNT + 1);

    localparam logic [FILL_W-1:0]    FILL_ZERO  = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0]    FILL_ONE   = FILL_W'(1);
    localparam logic [FILL_W-1:0]    FULL_CNT   = FILL_W'(DATA_COUNT);
    localparam logic [FILL_W-1:0]    STRIDE_CNT = FILL_W'(STRIDE);
    localparam logic [OVR_WIDTH-1:0] OVR_ONE    = OVR_WIDTH'(1);
    localparam logic [OVR_WIDTH-1:0] OVR_MAX    = {OVR_WIDTH{1'b1}};

    state_e                state_q, state_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [FILL_W-1:0]     stride_q, stride_d;
    logic                  primed_q, primed_d;
    logic                  valid_q, valid_d;
    logic [TOTAL_W-1:0]    win_q, win_d;
    logic [OVR_WIDTH-1:0]  ovr_q, ovr_d;
    logic                  accept_s;
    logic                  complete_s;
    logic [TOTAL_W-1:0]    shift_data_s;

    // A flush discards any sample strobed in the same cycle.
    assign accept_s = sample_valid & ~flush;

    sample_shift_reg #(
        .DATA_COUNT (DATA_COUNT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk          (clk),
        .rst_n        (rst),
        .shift_en_i   (accept_s),
        .clear_i      (flush),
        .din_i        (sample_data),
        .shift_data_o (shift_data_s)
    );

    // Fill/stride sequencing and window completion detection.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        stride_d   = stride_q;
        primed_d   = primed_q;
        complete_s = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            fill_d   = FILL_ZERO;
            stride_d = FILL_ZERO;
            primed_d = 1'b0;
        end else if (accept_s) begin
            case (state_q)
                ST_EMPTY: begin
                    state_d = ST_FILLING;
                    fill_d  = FILL_ONE;
                end
                ST_FILLING: begin
                    fill_d = fill_q + FILL_ONE;
                    if ((fill_q + FILL_ONE) == FULL_CNT) begin
                        state_d    = ST_PRIMED;
                        primed_d   = 1'b1;
                        stride_d   = FILL_ZERO;
                        complete_s = 1'b1;
                    end else begin
                        state_d = ST_FILLING;
                    end
                end
                ST_PRIMED: begin
                    if ((stride_q + FILL_ONE) == STRIDE_CNT) begin
                        stride_d   = FILL_ZERO;
                        complete_s = 1'b1;
                    end else begin
                        stride_d = stride_q + FILL_ONE;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    fill_d   = FILL_ZERO;
                    stride_d = FILL_ZERO;
                    primed_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Snapshot load, consumer handshake and saturating overrun count.
    always_comb begin
        valid_d = valid_q;
        win_d   = win_q;
        ovr_d   = ovr_q;
        if (window_ack && valid_q) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (complete_s) begin
            valid_d = 1'b1;
            win_d   = shift_data_s;
            if (valid_q && !window_ack && (ovr_q != OVR_MAX)) begin
                ovr_d = ovr_q + OVR_ONE;
            end else begin
                ovr_d = ovr_q;
            end
        end else begin
            win_d = win_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_EMPTY;
            fill_q   <= FILL_ZERO;
            stride_q <= FILL_ZERO;
            primed_q <= 1'b0;
            valid_q  <= 1'b0;
            win_q    <= {TOTAL_W{1'b0}};
            ovr_q    <= {OVR_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            stride_q <= stride_d;
            primed_q <= primed_d;
            valid_q  <= valid_d;
            win_q    <= win_d;
            ovr_q    <= ovr_d;
        end
    end

    assign window_data   = win_q;
    assign window_valid  = valid_q;
    assign fill_count    = fill_q;
    assign primed        = primed_q;
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_adc_window_buffer.sv
// Directed bench for adc_window_buffer: a block-window instance driven from a
// vector table plus corner sequences, and a STRIDE=4 sliding-window instance.
module tb_adc_window_buffer;
    import adc_pkg::*;

    localparam int N  = 16;
    localparam int W  = 12;
    localparam int OW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_a, a_sv, a_fl, a_ack;
    logic [W-1:0]     a_sd;
    logic [N*W-1:0]   a_win;
    logic             a_valid, a_primed;
    logic [4:0]       a_fill;
    logic [OW-1:0]    a_ovr;

    logic             rst_b, b_sv, b_fl, b_ack;
    logic [W-1:0]     b_sd;
    logic [N*W-1:0]   b_win;
    logic             b_valid, b_primed;
    logic [4:0]       b_fill;
    logic [OW-1:0]    b_ovr;

    int n_pass  = 0;
    int n_total = 0;

    adc_window_buffer #(.DATA_COUNT(N), .DATA_WIDTH(W), .STRIDE(16), .OVR_WIDTH(OW)) u_a (
        .clk(clk), .rst(rst_a), .sample_valid(a_sv), .sample_data(a_sd), .flush(a_fl),
        .window_ack(a_ack), .window_data(a_win), .window_valid(a_valid),
        .fill_count(a_fill), .primed(a_primed), .overrun_count(a_ovr)
    );

    adc_window_buffer #(.DATA_COUNT(N), .DATA_WIDTH(W), .STRIDE(4), .OVR_WIDTH(OW)) u_b (
        .clk(clk), .rst(rst_b), .sample_valid(b_sv), .sample_data(b_sd), .flush(b_fl),
        .window_ack(b_ack), .window_data(b_win), .window_valid(b_valid),
        .fill_count(b_fill), .primed(b_primed), .overrun_count(b_ovr)
    );

    typedef struct {
        logic          sv;
        logic [W-1:0]  sd;
        logic          ack;
        logic          exp_valid;
        logic [4:0]    exp_fill;
        logic          exp_primed;
        logic [OW-1:0] exp_ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [W-1:0] elem(input logic [N*W-1:0] w, input int i);
        return w[elem_lsb(i, W) +: W];
    endfunction

    task automatic chk_a(input string nm, input logic v, input logic [4:0] f,
                         input logic p, input logic [OW-1:0] o);
        chk({nm, " valid"},  32'(a_valid),  32'(v));
        chk({nm, " fill"},   32'(a_fill),   32'(f));
        chk({nm, " primed"}, 32'(a_primed), 32'(p));
        chk({nm, " ovr"},    32'(a_ovr),    32'(o));
    endtask

    task automatic chk_elem(input string nm, input logic [N*W-1:0] w, input int i,
                            input logic [W-1:0] exp);
        chk($sformatf("%s elem%0d", nm, i), 32'(elem(w, i)), 32'(exp));
    endtask

    task automatic a_step(input logic v, input logic [W-1:0] d, input logic f, input logic k);
        a_sv = v; a_sd = d; a_fl = f; a_ack = k;
        @(posedge clk); #1;
        a_sv = 1'b0; a_sd = '0; a_fl = 1'b0; a_ack = 1'b0;
    endtask

    task automatic a_feed(input int first, input int count);
        for (int i = 0; i < count; i++) a_step(1'b1, W'(first + i), 1'b0, 1'b0);
    endtask

    task automatic b_step(input logic v, input logic [W-1:0] d, input logic k);
        b_sv = v; b_sd = d; b_ack = k;
        @(posedge clk); #1;
        b_sv = 1'b0; b_sd = '0; b_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_v;
        logic exp_v;
        rst_a = 1'b0; a_sv = 1'b0; a_sd = '0; a_fl = 1'b0; a_ack = 1'b0;
        rst_b = 1'b0; b_sv = 1'b0; b_sd = '0; b_fl = 1'b0; b_ack = 1'b0;

        // Block window fill, ack, second block window.
        for (int k = 1; k <= 16; k++)
            tbl.push_back('{1'b1, W'(k), 1'b0, (k == 16), 5'(k), (k == 16), 8'd0});
        tbl.push_back('{1'b0, 12'h000, 1'b1, 1'b0, 5'd16, 1'b1, 8'd0});
        for (int k = 1; k <= 16; k++)
            tbl.push_back('{1'b1, W'(16 + k), 1'b0, (k == 16), 5'd16, 1'b1, 8'd0});

        #2;
        chk_a("reset", 1'b0, 5'd0, 1'b0, 8'd0);
        chk("reset win", 32'(a_win == '0), 32'd1);
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1;

        foreach (tbl[i]) begin
            a_step(tbl[i].sv, tbl[i].sd, 1'b0, tbl[i].ack);
            chk_a($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_fill,
                  tbl[i].exp_primed, tbl[i].exp_ovr);
            if (i == 15) begin
                chk_elem("win1", a_win, 0, 12'h001);
                chk_elem("win1", a_win, 7, 12'h008);
                chk_elem("win1", a_win, 15, 12'h010);
            end
        end
        chk_elem("win2", a_win, 0, 12'h011);
        chk_elem("win2", a_win, 15, 12'h020);

        // Overruns with no ack, then completion coinciding with ack.
        rst_a = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b1;
        a_feed(1, 48);
        chk_a("ovr48", 1'b1, 5'd16, 1'b1, 8'd2);
        chk_elem("ovr48", a_win, 0, 12'h021);
        chk_elem("ovr48", a_win, 15, 12'h030);
        a_feed(49, 15);
        a_step(1'b1, 12'h040, 1'b0, 1'b1);
        chk_a("ack64", 1'b1, 5'd16, 1'b1, 8'd2);
        chk_elem("ack64", a_win, 0, 12'h031);
        chk_elem("ack64", a_win, 15, 12'h040);

        // Flush keeps snapshot state; flush beats a simultaneous sample.
        a_step(1'b0, 12'h000, 1'b1, 1'b0);
        chk_a("flush1", 1'b1, 5'd0, 1'b0, 8'd2);
        chk_elem("flush1", a_win, 0, 12'h031);
        a_feed(12'h050, 10);
        chk_a("part10", 1'b1, 5'd10, 1'b0, 8'd2);
        a_step(1'b1, 12'h0AA, 1'b1, 1'b1);
        chk_a("flush2", 1'b0, 5'd0, 1'b0, 8'd2);
        a_feed(12'h100, 15);
        chk_a("refill15", 1'b0, 5'd15, 1'b0, 8'd2);
        a_step(1'b1, 12'h10F, 1'b0, 1'b0);
        chk_a("refill16", 1'b1, 5'd16, 1'b1, 8'd2);
        for (int i = 0; i < N; i++) chk_elem("refill", a_win, i, W'(12'h100 + i));

        // Asynchronous reset mid-fill with a pending snapshot.
        a_step(1'b0, 12'h000, 1'b1, 1'b0);
        a_feed(12'h200, 9);
        chk_a("prerst", 1'b1, 5'd9, 1'b0, 8'd2);
        #2;
        rst_a = 1'b0;
        #1;
        chk_a("asyncrst", 1'b0, 5'd0, 1'b0, 8'd0);
        chk("asyncrst win", 32'(a_win == '0), 32'd1);
        @(posedge clk); #1;
        rst_a = 1'b1;
        a_feed(12'h300, 15);
        chk_a("post15", 1'b0, 5'd15, 1'b0, 8'd0);
        a_step(1'b1, 12'h30F, 1'b0, 1'b0);
        chk_a("post16", 1'b1, 5'd16, 1'b1, 8'd0);
        chk_elem("post16", a_win, 0, 12'h300);
        chk_elem("post16", a_win, 15, 12'h30F);

        // STRIDE=4 sliding window, acking each snapshot on the next sample.
        prev_v = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            b_step(1'b1, W'(k), prev_v);
            exp_v = (k == 16) || (k == 20) || (k == 24);
            chk($sformatf("s4 valid k%0d", k), 32'(b_valid), 32'(exp_v));
            prev_v = exp_v;
        end
        chk_elem("s4", b_win, 0, 12'h009);
        chk_elem("s4", b_win, 15, 12'h018);
        chk("s4 ovr", 32'(b_ovr), 32'd0);
        chk("s4 fill", 32'(b_fill), 32'd16);
        chk("s4 primed", 32'(b_primed), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
